// File: rtl/rs232_stream_arbiter_if.sv
// Byte-stream bundle between the CHANNELS sources, the arbiter and the RS232 transmitter.
interface rs232_stream_arbiter_if #(
   parameter int unsigned CHANNELS = 4
);
   logic [8*CHANNELS-1:0] idata;
   logic [CHANNELS-1:0]   ivalid;
   logic [CHANNELS-1:0]   iready;
   logic [7:0]            odata;
   logic                  ovalid;
   logic                  oready;

   // master: byte producers plus transmitter side; slave: the arbiter
   modport master (output idata, output ivalid, input iready,
                   input odata, input ovalid, output oready);
   modport slave  (input idata, input ivalid, output iready,
                   output odata, output ovalid, input oready);
endinterface

// File: rtl/rs232_stream_arbiter.sv
// Round-robin burst arbiter: packs one source's burst behind a {channel,len-1} header byte.
// Optional trailing XOR checksum byte when RS232_STREAM_ARB_CHECKSUM_EN is defined.
module rs232_stream_arbiter #(
   parameter int unsigned CHANNELS  = 4,
   parameter int unsigned MAX_BURST = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   rs232_stream_arbiter_if.slave bus,
   output logic [2:0]           grant,
   output logic                 busy
);
   localparam int unsigned CW = $clog2(MAX_BURST + 1);
   localparam int unsigned IW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam int unsigned SW = $clog2(CHANNELS);

`ifdef RS232_STREAM_ARB_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, COLLECT, HEADER, DRAIN, CHECK} state_t;
`else
   typedef enum logic [1:0] {IDLE, COLLECT, HEADER, DRAIN} state_t;
`endif

   state_t              state_q, state_d;
   logic [2:0]          grant_q, grant_d;
   logic [2:0]          last_q, last_d;
   logic [CW-1:0]       count_q, count_d;
   logic [CW-1:0]       rd_q, rd_d;
   logic [CW-1:0]       exit_cnt;
   logic                col_exit;
   logic [CHANNELS-1:0] iready_q, iready_d;
   logic [7:0]          odata_q, odata_d;
   logic                ovalid_q, ovalid_d;
   logic                busy_q;
   logic [7:0]          buffer [MAX_BURST];
   logic                wr_en;
   logic [7:0]          wr_byte;
   logic                gvalid;
   logic                gready;
   logic [CHANNELS-1:0] grant_onehot;
   logic                sel_found;
   logic [2:0]          sel_idx;
   int                  sel_scan;
`ifdef RS232_STREAM_ARB_CHECKSUM_EN
   logic [7:0]          csum_q, csum_d;
`endif

   assign gvalid       = bus.ivalid[SW'(grant_q)];
   assign gready       = iready_q[SW'(grant_q)];
   assign wr_byte      = bus.idata[8*int'(grant_q) +: 8];
   assign grant_onehot = CHANNELS'(1) << grant_q;

   assign bus.iready = iready_q;
   assign bus.odata  = odata_q;
   assign bus.ovalid = ovalid_q;
   assign grant      = grant_q;
   assign busy       = busy_q;

   // Round-robin pick: first requesting channel after the last granted one.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_scan  = 0;
      for (int k = 1; k <= int'(CHANNELS); k++) begin
         sel_scan = int'(last_q) + k;
         if (sel_scan >= int'(CHANNELS)) sel_scan = sel_scan - int'(CHANNELS);
         if (!sel_found && bus.ivalid[SW'(sel_scan)]) begin
            sel_found = 1'b1;
            sel_idx   = 3'(sel_scan);
         end
      end
   end

   // Next-state and next-output decode; every output is registered from these.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      count_d  = count_q;
      rd_d     = rd_q;
      iready_d = '0;
      odata_d  = '0;
      ovalid_d = 1'b0;
      wr_en    = 1'b0;
      col_exit = 1'b0;
      exit_cnt = count_q;
`ifdef RS232_STREAM_ARB_CHECKSUM_EN
      csum_d   = csum_q;
`endif
      case (state_q)
         IDLE: begin
            if (sel_found) begin
               grant_d  = sel_idx;
               count_d  = '0;
               iready_d = CHANNELS'(1) << sel_idx;
               state_d  = COLLECT;
            end
         end
         COLLECT: begin
            if (!gvalid) begin
               col_exit = 1'b1;
            end else if (gready) begin
               wr_en   = 1'b1;
               count_d = count_q + CW'(1);
               if (count_d == CW'(MAX_BURST)) begin
                  col_exit = 1'b1;
                  exit_cnt = count_d;
               end else begin
                  iready_d = grant_onehot;
               end
            end
            if (col_exit) begin
               if (exit_cnt == '0) begin
                  last_d  = grant_q;
                  state_d = IDLE;
               end else begin
                  ovalid_d = 1'b1;
                  odata_d  = {grant_q, 5'(exit_cnt - CW'(1))};
`ifdef RS232_STREAM_ARB_CHECKSUM_EN
                  csum_d   = {grant_q, 5'(exit_cnt - CW'(1))};
`endif
                  state_d  = HEADER;
               end
            end
         end
         HEADER: begin
            ovalid_d = 1'b1;
            odata_d  = odata_q;
            if (bus.oready) begin
               rd_d    = '0;
               odata_d = buffer[0];
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            ovalid_d = 1'b1;
            odata_d  = odata_q;
            if (bus.oready) begin
`ifdef RS232_STREAM_ARB_CHECKSUM_EN
               csum_d = csum_q ^ odata_q;
`endif
               if (rd_q == count_q - CW'(1)) begin
`ifdef RS232_STREAM_ARB_CHECKSUM_EN
                  odata_d = csum_q ^ odata_q;
                  state_d = CHECK;
`else
                  ovalid_d = 1'b0;
                  odata_d  = '0;
                  last_d   = grant_q;
                  state_d  = IDLE;
`endif
               end else begin
                  rd_d    = rd_q + CW'(1);
                  odata_d = buffer[IW'(rd_q + CW'(1))];
               end
            end
         end
`ifdef RS232_STREAM_ARB_CHECKSUM_EN
         CHECK: begin
            ovalid_d = 1'b1;
            odata_d  = odata_q;
            if (bus.oready) begin
               ovalid_d = 1'b0;
               odata_d  = '0;
               last_d   = grant_q;
               state_d  = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         last_q   <= 3'(CHANNELS - 1);
         count_q  <= '0;
         rd_q     <= '0;
         iready_q <= '0;
         odata_q  <= '0;
         ovalid_q <= 1'b0;
         busy_q   <= 1'b0;
`ifdef RS232_STREAM_ARB_CHECKSUM_EN
         csum_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         count_q  <= count_d;
         rd_q     <= rd_d;
         iready_q <= iready_d;
         odata_q  <= odata_d;
         ovalid_q <= ovalid_d;
         busy_q   <= (state_d != IDLE);
`ifdef RS232_STREAM_ARB_CHECKSUM_EN
         csum_q   <= csum_d;
`endif
      end
   end

   // Payload storage needs no reset; count gates what is ever read back.
   always_ff @(posedge clock) begin
      if (!reset && wr_en) buffer[IW'(count_q)] <= wr_byte;
   end

endmodule

// File: tb/tb_rs232_stream_arbiter.sv
// Scoreboard bench for rs232_stream_arbiter: a burst-level round-robin model fills the expected byte queue.
module tb_rs232_stream_arbiter;
   localparam int unsigned CH = 4;
   localparam int unsigned MB = 16;

   logic       clock = 1'b0;
   logic       reset;
   logic [2:0] grant;
   logic       busy;

   rs232_stream_arbiter_if #(.CHANNELS(CH)) bus ();

   rs232_stream_arbiter #(.CHANNELS(CH), .MAX_BURST(MB)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus),
      .grant (grant),
      .busy  (busy)
   );

   always #5 clock = ~clock;

   logic [7:0]    src_q [CH][$];
   logic [7:0]    mdl_q [CH][$];
   logic [7:0]    exp_q [$];
   logic [CH-1:0] hs_in;
   int            model_last;
   int            n_checks;
   int            n_pass;
   int            out_seen;
   bit            rand_oready;
   bit            prev_stall;
   logic [7:0]    prev_data;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic push_byte(input int c, input logic [7:0] b);
      src_q[c].push_back(b);
      mdl_q[c].push_back(b);
   endtask

   // Burst-level reference: every loaded source is valid from the same cycle onward.
   task automatic model_run();
      int pick;
      int n;
      logic [7:0] hdr;
      logic [7:0] b;
`ifdef RS232_STREAM_ARB_CHECKSUM_EN
      logic [7:0] cs;
`endif
      forever begin
         pick = -1;
         for (int k = 1; k <= int'(CH); k++)
            if (pick < 0 && mdl_q[(model_last + k) % int'(CH)].size() > 0)
               pick = (model_last + k) % int'(CH);
         if (pick < 0) break;
         n   = (mdl_q[pick].size() > int'(MB)) ? int'(MB) : mdl_q[pick].size();
         hdr = {3'(pick), 5'(n - 1)};
         exp_q.push_back(hdr);
`ifdef RS232_STREAM_ARB_CHECKSUM_EN
         cs = hdr;
`endif
         for (int i = 0; i < n; i++) begin
            b = mdl_q[pick].pop_front();
            exp_q.push_back(b);
`ifdef RS232_STREAM_ARB_CHECKSUM_EN
            cs = cs ^ b;
`endif
         end
`ifdef RS232_STREAM_ARB_CHECKSUM_EN
         exp_q.push_back(cs);
`endif
         model_last = pick;
      end
   endtask

   task automatic drive_in();
      for (int c = 0; c < int'(CH); c++) begin
         bus.ivalid[c]        = (src_q[c].size() > 0);
         bus.idata[8*c +: 8]  = (src_q[c].size() > 0) ? src_q[c][0] : 8'h00;
      end
      hs_in = reset ? '0 : (bus.ivalid & bus.iready);
   endtask

   // One cycle: retire last edge's input handshakes, drive, then check the outgoing byte.
   task automatic step();
      @(negedge clock);
      for (int c = 0; c < int'(CH); c++)
         if (hs_in[c]) void'(src_q[c].pop_front());
      hs_in = '0;
      drive_in();
      bus.oready = rand_oready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!reset) begin
         if (prev_stall) begin
            check_eq("stall_ovalid", 32'(bus.ovalid), 32'd1);
            check_eq("stall_odata", 32'(bus.odata), 32'(prev_data));
         end
         if (bus.ovalid) check_eq("iready_while_out", 32'(bus.iready), 32'd0);
         if (bus.ovalid && bus.oready) begin
            check_eq("out_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               check_eq("odata", 32'(bus.odata), 32'(exp_q.pop_front()));
               out_seen++;
            end
         end
         prev_stall = bus.ovalid && !bus.oready;
         prev_data  = bus.odata;
      end else begin
         prev_stall = 1'b0;
      end
   endtask

   function automatic bit all_src_empty();
      bit e = 1'b1;
      for (int c = 0; c < int'(CH); c++) if (src_q[c].size() != 0) e = 1'b0;
      return e;
   endfunction

   task automatic wait_done(input string tag);
      int cyc = 0;
      bit done = 1'b0;
      while (!done && cyc < 3000) begin
         step();
         cyc++;
         done = (exp_q.size() == 0) && !busy && all_src_empty();
      end
      check_eq(tag, 32'(done), 32'd1);
   endtask

   task automatic flush_all();
      for (int c = 0; c < int'(CH); c++) begin
         src_q[c].delete();
         mdl_q[c].delete();
      end
      exp_q.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      flush_all();
      drive_in();
      step();
      step();
      check_eq("reset_ovalid", 32'(bus.ovalid), 32'd0);
      reset      = 1'b0;
      model_last = int'(CH) - 1;
      drive_in();
   endtask

   initial begin
      int cyc;
      n_checks    = 0;
      n_pass      = 0;
      out_seen    = 0;
      rand_oready = 1'b0;
      prev_stall  = 1'b0;
      prev_data   = '0;
      hs_in       = '0;
      model_last  = int'(CH) - 1;
      reset       = 1'b1;
      bus.ivalid  = '0;
      bus.idata   = '0;
      bus.oready  = 1'b1;
      repeat (3) step();
      check_eq("rst_ovalid", 32'(bus.ovalid), 32'd0);
      check_eq("rst_odata", 32'(bus.odata), 32'd0);
      check_eq("rst_iready", 32'(bus.iready), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_grant", 32'(grant), 32'd0);
      reset = 1'b0;
      drive_in();

      // Single short burst from channel 1, including the two-cycle acceptance latency.
      push_byte(1, 8'hA5);
      push_byte(1, 8'h3C);
      model_run();
      drive_in();
      step();
      check_eq("t1_first_iready", 32'(bus.iready), 32'h2);
      wait_done("t1_done");
      check_eq("t1_grant", 32'(grant), 32'd1);
      check_eq("t1_busy", 32'(busy), 32'd0);

      // Channel 0 streams 40 bytes: two full bursts and a short one.
      for (int i = 0; i < 40; i++) push_byte(0, 8'(i * 7 + 3));
      model_run();
      drive_in();
      wait_done("t2_done");

      // All channels busy after reset: strict 0,1,2,3 rotation.
      do_reset();
      for (int c = 0; c < int'(CH); c++)
         for (int i = 0; i < 20; i++) push_byte(c, 8'(c * 64 + i));
      model_run();
      drive_in();
      wait_done("t3_done");

      // Random backpressure from the transmitter.
      rand_oready = 1'b1;
      for (int i = 0; i < 5; i++) push_byte(1, 8'($urandom_range(0, 255)));
      for (int i = 0; i < 12; i++) push_byte(2, 8'($urandom_range(0, 255)));
      model_run();
      drive_in();
      wait_done("t4_done");
      rand_oready = 1'b0;

      // Reset in the middle of a channel 2 drain, then channel 3 alone.
      for (int i = 0; i < 10; i++) push_byte(2, 8'(8'hB0 + i));
      model_run();
      drive_in();
      out_seen = 0;
      cyc = 0;
      while (out_seen < 4 && cyc < 200) begin
         step();
         cyc++;
      end
      check_eq("t5_in_drain", 32'(out_seen >= 4), 32'd1);
      reset = 1'b1;
      flush_all();
      drive_in();
      step();
      check_eq("t5_ovalid_after_rst", 32'(bus.ovalid), 32'd0);
      check_eq("t5_busy_after_rst", 32'(busy), 32'd0);
      check_eq("t5_grant_after_rst", 32'(grant), 32'd0);
      reset      = 1'b0;
      model_last = int'(CH) - 1;
      push_byte(3, 8'h5A);
      push_byte(3, 8'hC3);
      model_run();
      drive_in();
      wait_done("t5_done");
      check_eq("t5_grant", 32'(grant), 32'd3);

      // Channel 3 two-byte burst (trailing checksum byte in the checksum build).
      push_byte(3, 8'h01);
      push_byte(3, 8'h02);
      model_run();
      drive_in();
      wait_done("t6_done");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
